cmd_resp_sequencer: RTL
=======================

// Module: cmd_resp_sequencer
// PURPOSE
//  Synthesizable command/response script engine for the Knight's-tour command link.
//  Holds a replayable queue of DEPTH entries {cmd, expected resp, check flag, timeout}.
//  Issues each entry over the send_cmd/cmd/cmd_sent handshake, then waits for resp_rdy
//  under a per-entry timeout and compares resp. Records the first failure.
//  Sits between the remote/UART command source and the command transmitter, for
//  self-test and on-chip regression.
// PARAMETERS
//  CMD_W        16       command width
//  RESP_W       8        response width
//  DEPTH        8        queue entries (power of 2, >=2)
//  TMO_W        23       timeout counter width
//  DEF_TMO      2750000  timeout in clk cycles used when entry ld_tmo==0
//  STOP_ON_ERR  1        1: halt sequence at first error; 0: log first error, run to end
// PORTS
//  clk       in   1                 system clock
//  RST_n     in   1                 synchronous active-low reset
//  ld_en     in   1                 append entry (accepted only in IDLE and !full)
//  ld_cmd    in   CMD_W             entry command
//  ld_exp    in   RESP_W            entry expected response
//  ld_chk    in   1                 1 = compare resp; 0 = only wait for resp_rdy
//  ld_tmo    in   TMO_W             entry timeout in cycles; 0 selects DEF_TMO
//  clr       in   1                 empty queue (IDLE only)
//  start     in   1                 run queue from entry 0 (IDLE only)
//  abort     in   1                 stop run, return to IDLE
//  cmd       out  CMD_W             command to transmitter
//  send_cmd  out  1                 one-cycle send strobe
//  cmd_sent  in   1                 transmitter done (rising edge used)
//  resp_rdy  in   1                 response valid (rising edge used)
//  resp      in   RESP_W            response byte
//  count     out  $clog2(DEPTH)+1   entries loaded
//  full      out  1                 count==DEPTH
//  busy      out  1                 run in progress
//  done      out  1                 one-cycle pulse at end of run (normal, error-halt or abort)
//  pass      out  1                 valid with done: 1 if no error recorded this run
//  err       out  1                 sticky until next start or reset
//  err_code  out  2                 01 cmd_sent timeout, 10 resp timeout, 11 mismatch
//  err_idx   out  $clog2(DEPTH)     entry index of first error
// BEHAVIOUR
//  - Reset: all outputs 0, queue emptied, edge-detect flops 0, FSM IDLE. Applies mid-run.
//  - Edge detect: rise = sig & ~sig_q, registered each cycle. resp_seen flag is set on a
//    resp_rdy rise, resp captured into resp_q on that same cycle, flag cleared in SEND.
//  - FSM: IDLE -> LOAD -> SEND -> WAIT_SENT -> WAIT_RESP -> CHECK -> LOAD | FIN;
//    FIN -> IDLE.
//  - IDLE: ld_en & !full writes at wr_ptr and increments count. clr zeroes count.
//    start: busy=1, rd_ptr=0, err cleared. With count==0, start goes straight to FIN.
//  - Priority in IDLE: clr > start > ld_en. ld_en/clr while busy are ignored.
//  - LOAD (1 cycle): cmd <= entry.cmd. cmd is held stable until the next LOAD.
//  - SEND (1 cycle): send_cmd=1. Timeout counter cleared.
//  - WAIT_SENT: cmd_sent rise -> WAIT_RESP with counter cleared.
//    counter==tmo-1 without a rise -> error 01.
//  - WAIT_RESP: exit when resp_seen (including a rise seen during WAIT_SENT).
//    Exactly tmo cycles without it -> error 10.
//  - CHECK (1 cycle): ld_chk & (resp_q != exp) -> error 11.
//    rd_ptr==count-1 -> FIN, else rd_ptr++ and -> LOAD.
//  - Error: first error latches err=1, err_code, err_idx; later errors do not overwrite.
//    STOP_ON_ERR=1 -> FIN. STOP_ON_ERR=0 -> continue as CHECK would.
//  - FIN: done=1 for 1 cycle, pass=~err, busy=0. Queue is retained, so start replays it.
//  - abort in any busy state -> FIN next cycle; send_cmd forced 0; pass=0.
//    abort beats timeout and check in the same cycle.
//  - Latency: start@T -> cmd valid T+1 -> send_cmd high T+2.
//    Minimum per entry: 5 cycles plus handshake waits.
// TESTING
//  1 Load {0000,A5,chk}{2000,A5,chk}{4000,A5,chk}, start. Model: cmd_sent 10 clk after
//    send_cmd, resp_rdy/A5 20 clk later -> 3 send_cmd pulses, cmd 0000/2000/4000,
//    done pass=1.
//  2 STOP_ON_ERR=1, entry1 model replies 5A -> err=1, err_code=11, err_idx=1,
//    cmd 4000 never sent, pass=0.
//  3 STOP_ON_ERR=0, same stimulus -> all 3 sent, err_idx=1, pass=0.
//    ld_chk=0 entry replying 5A -> no error.
//  4 ld_tmo=100, model never raises resp_rdy -> err_code=10 exactly 100 clk after
//    entering WAIT_RESP. No cmd_sent -> err_code=01.
//  5 DEPTH=8: 9 loads -> full=1, count=8, 9th dropped. clr -> count=0.
//    start on empty -> done pass=1 at T+1.
//  6 RST_n low 1 clk during WAIT_RESP -> all outputs 0, count 0.
//    abort during WAIT_SENT -> done, pass=0, busy=0.

Source files
------------

// File: rtl/cmd_resp_sequencer.sv
// Command/response script engine: replays a queue of {cmd, expected resp, check, timeout}
// entries over the send_cmd/cmd_sent handshake and records the first failing entry.
module cmd_resp_sequencer #(
    parameter int CMD_W       = 16,
    parameter int RESP_W      = 8,
    parameter int DEPTH       = 8,
    parameter int TMO_W       = 23,
    parameter int DEF_TMO     = 2750000,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                     clk,
    input  logic                     RST_n,
    input  logic                     ld_en,
    input  logic [CMD_W-1:0]         ld_cmd,
    input  logic [RESP_W-1:0]        ld_exp,
    input  logic                     ld_chk,
    input  logic [TMO_W-1:0]         ld_tmo,
    input  logic                     clr,
    input  logic                     start,
    input  logic                     abort,
    output logic [CMD_W-1:0]         cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [RESP_W-1:0]        resp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH)-1:0] err_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_CHECK, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [CMD_W-1:0]  cmd_mem [DEPTH];
    logic [RESP_W-1:0] exp_mem [DEPTH];
    logic              chk_mem [DEPTH];
    logic [TMO_W-1:0]  tmo_mem [DEPTH];

    logic [AW-1:0]     rd_ptr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_lim;
    logic              cmd_sent_q;
    logic              resp_rdy_q;
    logic              resp_seen;
    logic [RESP_W-1:0] resp_q;
    logic              aborted;

    logic              sent_rise;
    logic              resp_rise;
    logic              last_entry;
    logic              wr_en;
    logic              clr_en;
    logic              start_en;
    logic              load_cmd;
    logic [AW-1:0]     load_idx;
    logic              adv;
    logic              err_hit;
    logic [1:0]        err_code_hit;
    logic              tmo_clr;
    logic              abort_hit;

    assign sent_rise  = cmd_sent & ~cmd_sent_q;
    assign resp_rise  = resp_rdy & ~resp_rdy_q;
    assign last_entry = ({1'b0, rd_ptr} == (count - CW'(1)));
    assign full       = (count == CW'(DEPTH));
    // A zero per-entry timeout falls back to the default; the counter compares against limit-1.
    assign tmo_lim    = (tmo_mem[rd_ptr] == '0) ? TMO_W'(DEF_TMO - 1)
                                                : tmo_mem[rd_ptr] - TMO_W'(1);

    always_comb begin
        state_nxt    = state;
        clr_en       = 1'b0;
        start_en     = 1'b0;
        wr_en        = 1'b0;
        load_cmd     = 1'b0;
        load_idx     = rd_ptr + AW'(1);
        adv          = 1'b0;
        err_hit      = 1'b0;
        err_code_hit = 2'b00;
        tmo_clr      = 1'b0;
        abort_hit    = 1'b0;
        send_cmd     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        pass         = 1'b0;

        case (state)
            S_IDLE: begin
                if (clr) begin
                    clr_en = 1'b1;
                end else if (start) begin
                    start_en = 1'b1;
                    if (count == '0) begin
                        state_nxt = S_FIN;
                    end else begin
                        load_cmd  = 1'b1;
                        load_idx  = '0;
                        state_nxt = S_LOAD;
                    end
                end else if (ld_en && !full) begin
                    wr_en = 1'b1;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                send_cmd  = 1'b1;
                tmo_clr   = 1'b1;
                state_nxt = S_WAIT_SENT;
            end
            S_WAIT_SENT: begin
                busy = 1'b1;
                if (sent_rise) begin
                    tmo_clr   = 1'b1;
                    state_nxt = S_WAIT_RESP;
                end else if (tmo_cnt == tmo_lim) begin
                    err_hit      = 1'b1;
                    err_code_hit = 2'b01;
                end
            end
            S_WAIT_RESP: begin
                busy = 1'b1;
                if (resp_seen) begin
                    state_nxt = S_CHECK;
                end else if (tmo_cnt == tmo_lim) begin
                    err_hit      = 1'b1;
                    err_code_hit = 2'b10;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (chk_mem[rd_ptr] && (resp_q != exp_mem[rd_ptr])) begin
                    err_hit      = 1'b1;
                    err_code_hit = 2'b11;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                pass      = ~err & ~aborted;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Entry completion: either halt on error or step to the next entry / finish.
        if ((state == S_CHECK) || err_hit) begin
            if (err_hit && (STOP_ON_ERR != 0)) begin
                state_nxt = S_FIN;
            end else if (last_entry) begin
                state_nxt = S_FIN;
            end else begin
                adv       = 1'b1;
                load_cmd  = 1'b1;
                state_nxt = S_LOAD;
            end
        end

        if (busy && abort) begin
            state_nxt = S_FIN;
            abort_hit = 1'b1;
            err_hit   = 1'b0;
            adv       = 1'b0;
            load_cmd  = 1'b0;
            send_cmd  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            state      <= S_IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            cmd        <= '0;
            tmo_cnt    <= '0;
            cmd_sent_q <= 1'b0;
            resp_rdy_q <= 1'b0;
            resp_seen  <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_idx    <= '0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_sent_q <= cmd_sent;
            resp_rdy_q <= resp_rdy;
            if (state == S_SEND)
                resp_seen <= 1'b0;
            else if (resp_rise)
                resp_seen <= 1'b1;
            if (clr_en)
                count <= '0;
            else if (wr_en)
                count <= count + CW'(1);
            if (start_en) begin
                rd_ptr   <= '0;
                err      <= 1'b0;
                err_code <= 2'b00;
                err_idx  <= '0;
                aborted  <= 1'b0;
            end else if (adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (load_cmd)
                cmd <= cmd_mem[load_idx];
            if (tmo_clr)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (err_hit && !err) begin
                err      <= 1'b1;
                err_code <= err_code_hit;
                err_idx  <= rd_ptr;
            end
            if (abort_hit)
                aborted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_rise)
            resp_q <= resp;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            cmd_mem[count[AW-1:0]] <= ld_cmd;
            exp_mem[count[AW-1:0]] <= ld_exp;
            chk_mem[count[AW-1:0]] <= ld_chk;
            tmo_mem[count[AW-1:0]] <= ld_tmo;
        end
    end

endmodule
